collision_host_sequencer: RTL
=============================

// Module: collision_host_sequencer
// PURPOSE
//  Initiator side of the collision custom-instruction interface: a hardware host that drives the
//  start/n/dataa/datab/done/result handshake in place of the Nios II CPU. One user command (512-bit
//  base message + 32-bit target) becomes this instruction sequence: 8x n=0 message loads, 1x n=1
//  search start, n=3 polls until found or timeout, then n=2 and n=4 reads. Results return on a
//  valid/ready response port. Used for CPU-less throughput runs and as a bench driver.
// PARAMETERS
//  POLL_GAP      8      idle cycles between a completed instruction and the next n=3 poll (>=1)
//  MAX_POLLS     65535  n=3 polls before timeout (1..65535, 16-bit poll counter)
// PORTS
//  clk          in   1    system clock
//  reset        in   1    asynchronous, active-low reset
//  cmd_valid    in   1    command present
//  cmd_ready    out  1    high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_message  in   512  base message; word 0 = [511:480]
//  cmd_target   in   32   collision target
//  ci_clk_en    out  1    clock enable to responder
//  ci_start     out  1    one-cycle instruction start pulse
//  ci_n         out  3    instruction select
//  ci_dataa     out  32   operand a
//  ci_datab     out  32   operand b
//  ci_done      in   1    responder done; may be high in the same cycle as ci_start
//  ci_result    in   32   responder result, valid while ci_done=1
//  rsp_valid    out  1    response valid; held until rsp_ready
//  rsp_ready    in   1    response consumed
//  rsp_found    out  1    1 = collision found
//  rsp_timeout  out  1    1 = MAX_POLLS reached without a find
//  rsp_counter  out  32   n=2 result; 0 if not found
//  rsp_digests  out  32   n=4 result
//  rsp_polls    out  16   number of n=3 polls issued
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0 except cmd_ready; ci_clk_en goes to 1 one cycle after release.
//  States: IDLE > LOAD > START > GAP > POLL > READ_COL > READ_DIG > RESP > IDLE.
//  - IDLE: cmd_ready=1. On accept, latch message and target, clear poll count and response regs, go to LOAD with k=0.
//  - Issue rule for LOAD/START/POLL/READ_*: ci_start=1 for exactly one cycle with ci_n/ci_dataa/ci_datab
//    driven. These stay stable until the cycle in which ci_done=1, including the start cycle.
//    ci_result is captured in that cycle, and the next state follows on the next edge.
//    No new ci_start is issued before ci_done of the previous one. ci_start is never re-pulsed while waiting.
//  - LOAD k=0..7: n=0, dataa=msg[511-64k -:32], datab=msg[479-64k -:32]. After k=7 go to START.
//  - START: n=1, dataa=target, datab=0; then GAP.
//  - GAP: count POLL_GAP idle cycles (ci_start=0), then POLL.
//  - POLL: n=3, poll count +1. If result[0]=1, go to READ_COL.
//    Else, if poll count==MAX_POLLS, set rsp_timeout and go to READ_DIG (n=2 is not issued); otherwise go to GAP.
//  - READ_COL: n=2, capture rsp_counter, set rsp_found; then READ_DIG.
//  - READ_DIG: n=4, capture rsp_digests; then RESP.
//  - RESP: rsp_valid=1 with all rsp_* fields stable. Return to IDLE on the cycle rsp_valid&rsp_ready.
//    rsp_* keep their values until the next command is accepted.
//  Unused dataa/datab are driven 0. cmd_valid outside IDLE is ignored (cmd_ready=0).
//  rsp_found and rsp_timeout are never both 1.
//  Reset mid-operation aborts immediately with no partial response. The responder must share this reset
//  (inverted) so that its message and search state are cleared as well.
// TESTING
//  1. Reset asserted mid-POLL -> next cycle ci_start=0, rsp_valid=0, cmd_ready=1; fresh command then runs from LOAD k=0.
//  2. message={16{32'h0000_0001}}+index pattern, target=32'h0000_1234 -> 8 n=0 pulses with exact word pairs in
//     order, then n=1 with dataa=32'h0000_1234.
//  3. Model returns n=3 results 0,0,0,1; n=2 -> 32'hDEAD_BEEF; n=4 -> 32'h0000_0100
//     -> rsp found=1 timeout=0 counter=DEADBEEF digests=0x100 polls=4.
//  4. Model delays ci_done 3 cycles on every op -> ci_start high exactly 1 cycle per op; n/dataa/datab held 4 cycles.
//  5. MAX_POLLS=2, n=3 always 0 -> found=0 timeout=1 polls=2 counter=0; no n=2 issued; n=4 issued.
//  6. rsp_ready low 5 cycles in RESP -> rsp_valid and fields stable; cmd_valid held high is not accepted until after the handshake.

Source files
------------

// File: rtl/collision_host_sequencer_if.sv
// Command, custom-instruction and response signals between the collision host sequencer and its peers.
// master = sequencer side; slave = command source, responder and response sink.
interface collision_host_sequencer_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [511:0] cmd_message;
    logic [31:0]  cmd_target;

    logic         ci_clk_en;
    logic         ci_start;
    logic [2:0]   ci_n;
    logic [31:0]  ci_dataa;
    logic [31:0]  ci_datab;
    logic         ci_done;
    logic [31:0]  ci_result;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_found;
    logic         rsp_timeout;
    logic [31:0]  rsp_counter;
    logic [31:0]  rsp_digests;
    logic [15:0]  rsp_polls;

    modport master (
        input  cmd_valid, cmd_message, cmd_target, ci_done, ci_result, rsp_ready,
        output cmd_ready, ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab,
               rsp_valid, rsp_found, rsp_timeout, rsp_counter, rsp_digests, rsp_polls
    );

    modport slave (
        output cmd_valid, cmd_message, cmd_target, ci_done, ci_result, rsp_ready,
        input  cmd_ready, ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab,
               rsp_valid, rsp_found, rsp_timeout, rsp_counter, rsp_digests, rsp_polls
    );
endinterface

// File: rtl/collision_host_sequencer.sv
// Host driver for the collision custom instruction: one command -> 8 loads, start, paced polls, reads, response.
// Latency is responder-bound plus POLL_GAP idle cycles per poll; cmd_ready only in IDLE, response held until rsp_ready.
module collision_host_sequencer #(
    parameter int POLL_GAP  = 8,
    parameter int MAX_POLLS = 65535
) (
    input logic                        clk,
    input logic                        reset,
    collision_host_sequencer_if.master bus
);

    localparam int              GAP_W      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(POLL_GAP - 1);
    localparam logic [15:0]     POLL_LIMIT = 16'(MAX_POLLS);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, GAP, POLL, READ_COL, READ_DIG, RESP
    } seqState_t;

    seqState_t        state, nextState;
    logic [511:0]     message;
    logic [31:0]      target;
    logic [2:0]       loadIdx;
    logic             issued;
    logic [GAP_W-1:0] gapCnt;
    logic [15:0]      pollCount;
    logic [15:0]      pollNext;
    logic             rspFound;
    logic             rspTimeout;
    logic [31:0]      rspCounter;
    logic [31:0]      rspDigests;
    logic             clkEn;

    logic             accept;
    logic             issueState;
    logic             opDone;
    logic [2:0]       opN;
    logic [31:0]      opA;
    logic [31:0]      opB;

    assign accept   = bus.cmd_valid && (state == IDLE);
    assign opDone   = issueState && bus.ci_done;
    assign pollNext = pollCount + 16'd1;

    always_comb begin
        nextState  = state;
        issueState = 1'b0;
        opN        = 3'd0;
        opA        = 32'd0;
        opB        = 32'd0;
        case (state)
            IDLE: begin
                if (accept) nextState = LOAD;
            end
            LOAD: begin
                // message shifts up one word pair per completed load, so the pair is always on top
                issueState = 1'b1;
                opA        = message[511:480];
                opB        = message[479:448];
                if (bus.ci_done && loadIdx == 3'd7) nextState = START;
            end
            START: begin
                issueState = 1'b1;
                opN        = 3'd1;
                opA        = target;
                if (bus.ci_done) nextState = GAP;
            end
            GAP: begin
                if (gapCnt == GAP_LAST) nextState = POLL;
            end
            POLL: begin
                issueState = 1'b1;
                opN        = 3'd3;
                if (bus.ci_done) begin
                    if (bus.ci_result[0])          nextState = READ_COL;
                    else if (pollNext == POLL_LIMIT) nextState = READ_DIG;
                    else                           nextState = GAP;
                end
            end
            READ_COL: begin
                issueState = 1'b1;
                opN        = 3'd2;
                if (bus.ci_done) nextState = READ_DIG;
            end
            READ_DIG: begin
                issueState = 1'b1;
                opN        = 3'd4;
                if (bus.ci_done) nextState = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            message    <= '0;
            target     <= '0;
            loadIdx    <= '0;
            issued     <= 1'b0;
            gapCnt     <= '0;
            pollCount  <= '0;
            rspFound   <= 1'b0;
            rspTimeout <= 1'b0;
            rspCounter <= '0;
            rspDigests <= '0;
            clkEn      <= 1'b0;
        end else begin
            state <= nextState;
            clkEn <= 1'b1;
            // issued marks "start already sent, waiting for done" so the pulse is never repeated
            issued <= issueState && !bus.ci_done;
            gapCnt <= (state == GAP) ? gapCnt + GAP_W'(1) : '0;

            if (accept) begin
                message    <= bus.cmd_message;
                target     <= bus.cmd_target;
                loadIdx    <= '0;
                pollCount  <= '0;
                rspFound   <= 1'b0;
                rspTimeout <= 1'b0;
                rspCounter <= '0;
                rspDigests <= '0;
            end

            if (opDone) begin
                case (state)
                    LOAD: begin
                        message <= message << 64;
                        loadIdx <= loadIdx + 3'd1;
                    end
                    POLL: begin
                        pollCount <= pollNext;
                        if (!bus.ci_result[0] && pollNext == POLL_LIMIT) rspTimeout <= 1'b1;
                    end
                    READ_COL: begin
                        rspCounter <= bus.ci_result;
                        rspFound   <= 1'b1;
                    end
                    READ_DIG: rspDigests <= bus.ci_result;
                    default: ;
                endcase
            end
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.ci_clk_en   = clkEn;
    assign bus.ci_start    = issueState && !issued;
    assign bus.ci_n        = opN;
    assign bus.ci_dataa    = opA;
    assign bus.ci_datab    = opB;
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_found   = rspFound;
    assign bus.rsp_timeout = rspTimeout;
    assign bus.rsp_counter = rspCounter;
    assign bus.rsp_digests = rspDigests;
    assign bus.rsp_polls   = pollCount;

endmodule
